sram22_port_ctrl: RTL
=====================

Name: sram22_port_ctrl

Overview:
- Initiator-side controller for the sram22 single-port macros, e.g. 2048x64 with byte write mask.
- Converts a valid/ready request channel into the macro's ce/we/wmask/addr/din pin protocol.
- Captures the registered dout one cycle after each read and returns it on a valid/ready response channel with backpressure.
- Optionally zero-fills the array after reset before accepting traffic.

Parameters:
- DATA_WIDTH, 64, word width; must be a multiple of 8.
- ADDR_WIDTH, 11, address width; the array holds 2**ADDR_WIDTH words.
- WMASK_WIDTH, DATA_WIDTH/8, one mask bit per byte.
- RSP_DEPTH, 2, response FIFO entries; minimum 2.
- CLEAR_ON_RESET, 1, when 1 the block zero-fills every word after reset.

Ports:
- clk  in  1  single clock; also drives the macro clock.
- rstb  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_we  in  1  1=write, 0=read.
- req_wmask  in  WMASK_WIDTH  byte enables (write only).
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  clear finished; traffic allowed.
- sram_rstb  out  1  macro reset bar.
- sram_ce  out  1  macro chip enable.
- sram_we  out  1  macro write enable.
- sram_wmask  out  WMASK_WIDTH  macro write mask.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro data in.
- sram_dout  in  DATA_WIDTH  macro data out (registered in macro).

Behaviour:
- Reset (rstb=0, async) clears: state, FIFO, counters, rd_inflight, rsp_valid, init_done.
- sram_rstb is reset-synchronised: asserts immediately with rstb; deasserts on the 2nd clk edge after rstb rises (2-flop).
- While sram_rstb=0: req_ready=0 and sram_ce=0.
- FSM states:
  - RESET_WAIT: holds until sram_rstb=1, then goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR: per cycle drives sram_ce=1, sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=clr_cnt; clr_cnt increments 0..2**ADDR_WIDTH-1. After the last address, goes to RUN; clr_cnt wraps to 0. req_ready=0 throughout.
  - RUN: init_done=1 (registered, rises the cycle RUN is entered).
- Pin drive in RUN is combinational from the request:
  - sram_ce = req_valid && req_ready.
  - sram_we = req_we.
  - sram_addr = req_addr, sram_din = req_wdata.
  - sram_wmask = req_we ? req_wmask : 0.
- Outside CLEAR/accept, sram_ce=0; other pins hold don't-care values but must not be X.
- Read latency: read accepted at edge N; the macro updates dout at edge N; the block captures sram_dout into the FIFO at edge N+1 (rd_inflight=1 during cycle N+1).
  - rsp_valid rises in cycle N+1 when the FIFO is empty (bypass allowed, zero added latency after capture).
  - The FIFO is registered; rsp_rdata is stable while rsp_valid && !rsp_ready.
- Writes: one cycle, no response generated. A write does not disturb held dout.
- Credit rule: req_ready = RUN && (fifo_count + rd_inflight < RSP_DEPTH) (a pure registered/count function, independent of req_valid). Writes are also blocked by this rule; this keeps ordering trivial.
- Throughput: one read per cycle sustained when rsp_ready=1; no bubble on back-to-back reads.
- Simultaneous capture and pop: the FIFO count is unchanged and data order is preserved.
- Same-address write then read in consecutive cycles: the read returns the new data (the macro writes at edge N, reads at N+1).
- Reset mid-CLEAR or mid-RUN: everything is discarded; a pending response is lost; CLEAR restarts from address 0.

Decomposition:
- Shared package sram22_pkg holds:
  - localparams for the macro geometries (DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH per macro);
  - the FSM state enum {RESET_WAIT, CLEAR, RUN};
  - the request struct (we, wmask, addr, wdata).
- One natural sub-module: sram22_rsp_fifo (parameterised synchronous FIFO with bypass, count output).

Test Plan:
- Reset/clear, CLEAR_ON_RESET=1, ADDR_WIDTH=4: release rstb -> sram_rstb high 2 edges later; 16 consecutive sram_ce=1/we=1/din=0 cycles at addr 0..15; init_done=1 next cycle; req_ready=0 until then.
- Byte write then read: write addr 5, data 0x1122334455667788, wmask 0xFF; then write addr 5, data 0xAAAA..AA, wmask 0x01; read addr 5 -> rsp_rdata 0x11223344556677AA, one cycle after the read is accepted.
- Back-to-back reads, addresses 0..7 (preloaded value=addr), rsp_ready=1: 8 responses on 8 consecutive cycles, in order, req_ready never low.
- Backpressure, rsp_ready=0: issue reads -> req_ready drops after 2 outstanding; rsp_rdata is held stable; raise rsp_ready -> the remaining data drains in order with no loss or duplication.
- Reset mid-operation: assert rstb while 2 responses are buffered and CLEAR_ON_RESET=1 -> rsp_valid=0 immediately (async); the clear restarts at addr 0; the old responses never appear.
- CLEAR_ON_RESET=0: init_done=1 and req_ready=1 on the cycle after sram_rstb rises; the first read returns no X-dependent control (rsp_valid timing is exact).

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared definitions for the sram22 single-port macro controllers:
// macro geometries, controller FSM states and the request record.
package sram22_pkg;

  localparam int SRAM22_2048X64_DATA_WIDTH  = 64;
  localparam int SRAM22_2048X64_ADDR_WIDTH  = 11;
  localparam int SRAM22_2048X64_WMASK_WIDTH = 8;

  localparam int SRAM22_1024X32_DATA_WIDTH  = 32;
  localparam int SRAM22_1024X32_ADDR_WIDTH  = 10;
  localparam int SRAM22_1024X32_WMASK_WIDTH = 4;

  localparam int SRAM22_512X128_DATA_WIDTH  = 128;
  localparam int SRAM22_512X128_ADDR_WIDTH  = 9;
  localparam int SRAM22_512X128_WMASK_WIDTH = 16;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    CLEAR      = 2'd1,
    RUN        = 2'd2
  } sram22_state_e;

  typedef struct packed {
    logic                                  we;
    logic [SRAM22_2048X64_WMASK_WIDTH-1:0] wmask;
    logic [SRAM22_2048X64_ADDR_WIDTH-1:0]  addr;
    logic [SRAM22_2048X64_DATA_WIDTH-1:0]  wdata;
  } sram22_req_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Read-response FIFO with same-cycle bypass when empty; the head is
// registered, so the output holds steady while the consumer stalls.
module sram22_rsp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push that is consumed straight through the bypass is never stored.
  assign empty_s     = (count_q == '0);
  assign wr_en_s     = push_i && !(empty_s && pop_i);
  assign rd_en_s     = pop_i && !empty_s;
  assign out_valid_o = !empty_s || push_i;
  assign out_data_o  = empty_s ? push_data_i : mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (wr_en_s && !rd_en_s) count_q <= count_q + CNT_W'(1);
      else if (rd_en_s && !wr_en_s) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sram22_port_ctrl.sv
// Initiator-side controller for an sram22 single-port macro: request channel
// to macro pins, optional zero-fill after reset, credited read responses.
module sram22_port_ctrl
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 11,
  parameter int WMASK_WIDTH    = DATA_WIDTH / 8,
  parameter int RSP_DEPTH      = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  sram22_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
  logic [1:0]             rst_sync_q;
  logic                   init_done_q;
  logic                   rd_inflight_q;
  logic [CNT_W-1:0]       fifo_count_s;
  logic [CNT_W:0]         credit_used_s;
  logic                   accept_s;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign sram_rstb = rst_sync_q[1];

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_used_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, rd_inflight_q};
  assign req_ready     = (state_q == RUN) && (credit_used_s < (CNT_W + 1)'(RSP_DEPTH));
  assign accept_s      = req_valid && req_ready;
  assign init_done     = init_done_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    case (state_q)
      RESET_WAIT: begin
        if (sram_rstb) state_d = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
        else           state_d = RESET_WAIT;
      end
      CLEAR: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) state_d = RUN;
        else                 state_d = CLEAR;
      end
      RUN: begin
        sram_ce    = accept_s;
        sram_we    = req_we;
        sram_wmask = req_we ? req_wmask : '0;
        sram_addr  = req_addr;
        sram_din   = req_wdata;
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= RESET_WAIT;
      clr_cnt_q     <= '0;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      init_done_q   <= (state_d == RUN);
      rd_inflight_q <= accept_s && !req_we;
    end
  end

  // The macro's registered dout is valid the cycle after the read edge.
  sram22_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rstb        (rstb),
    .push_i      (rd_inflight_q),
    .push_data_i (sram_dout),
    .pop_i       (rsp_ready),
    .out_valid_o (rsp_valid),
    .out_data_o  (rsp_rdata),
    .count_o     (fifo_count_s)
  );

endmodule
